// File: rtl/uart_rx_pkg.sv
// Shared UART constants and receiver FSM encoding.
// The transmitter imports the same values so both ends of the line agree.
package uart_rx_pkg;

    localparam int NB_STATE   = 2;
    localparam int C_DBIT     = 8;
    localparam int C_SB_TICK  = 16;
    localparam int C_BAUD_DIV = 163;   // 50 MHz / (19200 * 16)
    localparam int C_NB_DIV   = 8;

    typedef enum logic [NB_STATE-1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b10,
        ST_STOP  = 2'b11
    } state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver result bundle: received byte, status pulses, busy and FSM state for debug.
// o_rx_done and o_frame_err are single-cycle strobes with no back-pressure; o_data is valid whenever o_rx_done is high and holds until the next good frame.
interface uart_rx_if #(
    parameter int DBIT = 8
);
    import uart_rx_pkg::*;

    logic [DBIT-1:0] o_data;
    logic            o_rx_done;
    logic            o_frame_err;
    logic            o_busy;
    state_t          dbg_state;

    modport master (
        output o_data, o_rx_done, o_frame_err, o_busy, dbg_state
    );

    modport slave (
        input o_data, o_rx_done, o_frame_err, o_busy, dbg_state
    );

endinterface

// File: rtl/uart_rx_baud_rate_gen.sv
// Free-running oversampling tick generator: one-cycle o_tick every BAUD_DIV clocks.
module baud_rate_gen #(
    parameter int BAUD_DIV = 163,
    parameter int NB_DIV   = 8
) (
    input  logic i_clock,
    input  logic i_reset,
    output logic o_tick
);

    localparam logic [NB_DIV-1:0] DIV_LAST = NB_DIV'(BAUD_DIV - 1);

    logic [NB_DIV-1:0] r_count;
    logic              w_last;

    assign w_last = (r_count == DIV_LAST);
    assign o_tick = w_last;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_count <= '0;
        end else if (w_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, centre-of-bit sampling and framing-error detection.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DBIT     = C_DBIT,
    parameter int SB_TICK  = C_SB_TICK,
    parameter int BAUD_DIV = C_BAUD_DIV,
    parameter int NB_DIV   = C_NB_DIV
) (
    input  logic      i_clock,
    input  logic      i_reset,
    input  logic      i_rx,
    uart_rx_if.master rx_bus
);

    localparam logic [3:0] S_MID      = 4'd7;
    localparam logic [3:0] S_BIT_LAST = 4'd15;
    localparam logic [3:0] S_STOP     = 4'(SB_TICK - 1);
    localparam logic [2:0] N_LAST     = 3'(DBIT - 1);

    logic            w_tick;
    logic            r_rx_meta;
    logic            r_rx_s;
    state_t          r_state;
    state_t          w_state_nx;
    logic [3:0]      r_s;
    logic [3:0]      w_s_nx;
    logic [2:0]      r_n;
    logic [2:0]      w_n_nx;
    logic [DBIT-1:0] r_shift;
    logic [DBIT-1:0] w_shift_nx;
    logic [DBIT-1:0] r_data;
    logic [DBIT-1:0] w_data_nx;
    logic            r_armed;
    logic            w_armed_nx;
    logic            r_rx_done;
    logic            w_done_nx;
    logic            r_frame_err;
    logic            w_err_nx;

    baud_rate_gen #(
        .BAUD_DIV (BAUD_DIV),
        .NB_DIV   (NB_DIV)
    ) u_baud (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .o_tick  (w_tick)
    );

    // Synchronizer resets to the idle-line level so reset never looks like a start edge.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= ST_IDLE;
            r_s         <= '0;
            r_n         <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_armed     <= 1'b0;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_s         <= w_s_nx;
            r_n         <= w_n_nx;
            r_shift     <= w_shift_nx;
            r_data      <= w_data_nx;
            r_armed     <= w_armed_nx;
            r_rx_done   <= w_done_nx;
            r_frame_err <= w_err_nx;
        end
    end

    // armed blocks a new start until the line has been seen high (break / post-reset).
    always_comb begin
        w_state_nx = r_state;
        w_s_nx     = r_s;
        w_n_nx     = r_n;
        w_shift_nx = r_shift;
        w_data_nx  = r_data;
        w_armed_nx = r_armed;
        w_done_nx  = 1'b0;
        w_err_nx   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_rx_s) begin
                    w_armed_nx = 1'b1;
                end else if (r_armed) begin
                    w_state_nx = ST_START;
                    w_s_nx     = '0;
                    w_armed_nx = 1'b0;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    if (r_s == S_MID) begin
                        w_s_nx = '0;
                        if (!r_rx_s) begin
                            w_state_nx = ST_DATA;
                            w_n_nx     = '0;
                        end else begin
                            w_state_nx = ST_IDLE;
                        end
                    end else begin
                        w_s_nx = r_s + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_s == S_BIT_LAST) begin
                        w_s_nx     = '0;
                        w_shift_nx = {r_rx_s, r_shift[DBIT-1:1]};
                        if (r_n == N_LAST) begin
                            w_state_nx = ST_STOP;
                        end else begin
                            w_n_nx = r_n + 1'b1;
                        end
                    end else begin
                        w_s_nx = r_s + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_s == S_STOP) begin
                        w_state_nx = ST_IDLE;
                        w_s_nx     = '0;
                        if (r_rx_s) begin
                            w_data_nx  = r_shift;
                            w_done_nx  = 1'b1;
                            w_armed_nx = 1'b1;
                        end else begin
                            w_err_nx   = 1'b1;
                            w_armed_nx = 1'b0;
                        end
                    end else begin
                        w_s_nx = r_s + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    assign rx_bus.o_data      = r_data;
    assign rx_bus.o_rx_done   = r_rx_done;
    assign rx_bus.o_frame_err = r_frame_err;
    assign rx_bus.o_busy      = (r_state != ST_IDLE);
    assign rx_bus.dbg_state   = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx, run with a short baud divider to keep frames small.
`timescale 1ns/1ps
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int BAUD_DIV = 4;
    localparam int NB_DIV   = 3;
    localparam int BIT_CYC  = 16 * BAUD_DIV;

    logic clk;
    logic rst_n;
    logic rx;

    uart_rx_if #(.DBIT(8)) rx_bus ();

    uart_rx #(
        .DBIT     (8),
        .SB_TICK  (16),
        .BAUD_DIV (BAUD_DIV),
        .NB_DIV   (NB_DIV)
    ) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .i_rx    (rx),
        .rx_bus  (rx_bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    logic [8:0] exp_q[$];          // {frame_err, data}
    logic [7:0] exp_last;
    int         n_checks;
    int         n_errors;
    int         n_done;
    int         n_err;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (rx_bus.o_rx_done || rx_bus.o_frame_err)) begin
            if (rx_bus.o_rx_done) n_done++;
            if (rx_bus.o_frame_err) n_err++;
            check_val("pulse_excl", 32'(rx_bus.o_rx_done & rx_bus.o_frame_err), 32'd0);
            if (exp_q.size() == 0) begin
                check_val("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check_val("frame", {23'd0, rx_bus.o_frame_err, rx_bus.o_data}, {23'd0, e});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic line(input logic v, input int cyc);
        rx = v;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok, input int bit_cyc);
        if (stop_ok) begin
            exp_q.push_back({1'b0, b});
            exp_last = b;
        end else begin
            exp_q.push_back({1'b1, exp_last});
        end
        line(1'b0, bit_cyc);
        for (int i = 0; i < 8; i++) line(b[i], bit_cyc);
        line(stop_ok, bit_cyc);
    endtask

    task automatic drain(input string tag);
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 4 * BIT_CYC) begin
            @(negedge clk);
            waited++;
        end
        check_val(tag, exp_q.size(), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0; n_errors = 0; n_done = 0; n_err = 0;
        exp_last = 8'h00;
        rx = 1'b1;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check_val("rst_data",  rx_bus.o_data, 32'h0);
        check_val("rst_done",  rx_bus.o_rx_done, 32'h0);
        check_val("rst_ferr",  rx_bus.o_frame_err, 32'h0);
        check_val("rst_busy",  rx_bus.o_busy, 32'h0);
        check_val("rst_state", rx_bus.dbg_state, ST_IDLE);
        rst_n = 1'b1;
        line(1'b1, 10 * BIT_CYC);

        // Separated frames
        send_byte(8'h55, 1'b1, BIT_CYC); line(1'b1, 10 * BIT_CYC);
        send_byte(8'h01, 1'b1, BIT_CYC); line(1'b1, 10 * BIT_CYC);
        send_byte(8'h20, 1'b1, BIT_CYC); line(1'b1, 2 * BIT_CYC);
        drain("drain_sep");
        check_val("hold_20", rx_bus.o_data, 32'h20);

        // Back-to-back frames
        send_byte(8'hA5, 1'b1, BIT_CYC);
        send_byte(8'h3C, 1'b1, BIT_CYC);
        line(1'b1, 2 * BIT_CYC);
        drain("drain_b2b");

        // Short glitch: 3 ticks low
        line(1'b0, 6);
        check_val("glitch_busy", rx_bus.o_busy, 32'h1);
        line(1'b0, 3 * BAUD_DIV - 6);
        line(1'b1, 60);
        check_val("glitch_idle", rx_bus.o_busy, 32'h0);
        line(1'b1, 2 * BIT_CYC);

        // Framing error followed by a break
        send_byte(8'hC3, 1'b0, BIT_CYC);
        for (int k = 0; k < 5; k++) begin
            line(1'b0, 8 * BIT_CYC);
            check_val("break_idle", rx_bus.o_busy, 32'h0);
        end
        check_val("break_data", rx_bus.o_data, 32'h3C);
        drain("drain_ferr");
        line(1'b1, 2 * BIT_CYC);
        send_byte(8'h7E, 1'b1, BIT_CYC);
        line(1'b1, 2 * BIT_CYC);
        drain("drain_7e");

        // Reset in the middle of the data bits of 0xFF
        line(1'b0, BIT_CYC);
        line(1'b1, 3 * BIT_CYC);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_val("mid_rst_data", rx_bus.o_data, 32'h0);
        check_val("mid_rst_busy", rx_bus.o_busy, 32'h0);
        repeat (48) @(negedge clk);
        rst_n = 1'b1;
        exp_last = 8'h00;
        line(1'b1, 12 * BIT_CYC);
        send_byte(8'h81, 1'b1, BIT_CYC);
        line(1'b1, 2 * BIT_CYC);
        drain("drain_81");
        check_val("after_rst_data", rx_bus.o_data, 32'h81);

        // Baud skew of about -3% and +3%
        send_byte(8'h96, 1'b1, BIT_CYC - 2); line(1'b1, 3 * BIT_CYC);
        send_byte(8'h96, 1'b1, BIT_CYC + 2); line(1'b1, 3 * BIT_CYC);
        drain("drain_skew");

        check_val("done_count", n_done, 32'd9);
        check_val("ferr_count", n_err, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
